// File: rtl/condlogic_pipe_pkg.sv
// Shared definitions for the Execute-stage conditional-execution unit:
// ARM condition encodings, flag bit positions and the gated write-control bundle.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'ha;
  localparam logic [3:0] COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc;
  localparam logic [3:0] COND_LE = 4'hd;
  localparam logic [3:0] COND_AL = 4'he;
  localparam logic [3:0] COND_NV = 4'hf;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic pcs;
    logic rw;
    logic mw;
  } wrctl_t;

endpackage

// File: rtl/condlogic_pipe_if.sv
// Execute-stage control bundle between the pipeline and the conditional unit.
// master = pipeline driving E-stage controls, slave = condlogic_pipe.
interface condlogic_pipe_if #(
  parameter int unsigned FLAG_GRPS = 2
);
  logic                 StallE;
  logic                 FlushE;
  logic                 ValidE;
  logic [3:0]           CondE;
  logic [FLAG_GRPS-1:0] FlagWE;
  logic                 PCSE;
  logic                 RegWE;
  logic                 MemWE;
  logic                 BranchE;
  logic [3:0]           ALUFlags;
  logic                 FlagLd;
  logic [3:0]           FlagLdVal;
  logic [3:0]           Flags;
  logic                 CondExE;
  logic                 BranchTakenE;
  logic                 PCSrcM;
  logic                 RegWriteM;
  logic                 MemWriteM;

  modport master (
    output StallE, FlushE, ValidE, CondE, FlagWE, PCSE, RegWE, MemWE, BranchE,
           ALUFlags, FlagLd, FlagLdVal,
    input  Flags, CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM
  );

  modport slave (
    input  StallE, FlushE, ValidE, CondE, FlagWE, PCSE, RegWE, MemWE, BranchE,
           ALUFlags, FlagLd, FlagLdVal,
    output Flags, CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM
  );
endinterface

// File: rtl/condlogic_pipe_cond_eval.sv
// Combinational ARM condition-field evaluator against an NZCV flag vector.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (Cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/condlogic_pipe.sv
// Execute-stage conditional-execution unit: NZCV register with grouped writes and
// a direct load path, condition evaluation, and stall/flush-aware write gating.
module condlogic_pipe
  import cond_pkg::*;
#(
  parameter int unsigned FLAG_GRPS = 2,
  parameter bit          PIPE_OUT  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  condlogic_pipe_if.slave   bus
);

  localparam int unsigned GW = 4 / FLAG_GRPS;

  if (!(FLAG_GRPS == 1 || FLAG_GRPS == 2 || FLAG_GRPS == 4)) begin : g_bad_grps
    $error("condlogic_pipe: FLAG_GRPS must be 1, 2 or 4");
  end

  logic       live;
  logic       pass;
  logic       cond_ex;
  logic       commit;
  logic [3:0] flags_q;
  wrctl_t     ctl_e;

  assign live    = bus.ValidE & ~bus.FlushE;
  assign cond_ex = live & pass;
  assign commit  = cond_ex & ~bus.StallE;

  // Evaluated against the registered flags only; a flag-setting predecessor
  // has already committed at the end of its own E cycle.
  cond_eval u_eval (
    .Cond  (bus.CondE),
    .Flags (flags_q),
    .pass  (pass)
  );

  for (genvar g = 0; g < FLAG_GRPS; g++) begin : g_grp
    logic [GW-1:0] q;

    always_ff @(posedge clk) begin
      if (reset) begin
        q <= '0;
      end else if (bus.FlagLd) begin
        q <= bus.FlagLdVal[g*GW +: GW];
      end else if (bus.FlagWE[g] && commit) begin
        q <= bus.ALUFlags[g*GW +: GW];
      end
    end

    assign flags_q[g*GW +: GW] = q;
  end

  assign ctl_e = '{pcs: bus.PCSE  & commit,
                   rw:  bus.RegWE & commit,
                   mw:  bus.MemWE & commit};

  assign bus.Flags        = flags_q;
  assign bus.CondExE      = cond_ex;
  assign bus.BranchTakenE = bus.BranchE & commit;

  if (PIPE_OUT) begin : g_pipe
    wrctl_t ctl_m;

    always_ff @(posedge clk) begin
      if (reset) begin
        ctl_m <= '0;
      end else begin
        ctl_m <= ctl_e;
      end
    end

    assign bus.PCSrcM    = ctl_m.pcs;
    assign bus.RegWriteM = ctl_m.rw;
    assign bus.MemWriteM = ctl_m.mw;
  end else begin : g_comb
    assign bus.PCSrcM    = ctl_e.pcs;
    assign bus.RegWriteM = ctl_e.rw;
    assign bus.MemWriteM = ctl_e.mw;
  end

endmodule

// File: tb/tb_condlogic_pipe.sv
// Bench for condlogic_pipe: a 2-group registered-output instance and a 4-group
// combinational-output instance share stimulus and are compared to a flag model.
module tb_condlogic_pipe;
  import cond_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       stall, flush, valid, pcs, rw, mw, br, fld;
  logic [3:0] cond, alu, ldval;
  logic [1:0] fwe2;
  logic [3:0] fwe4;

  condlogic_pipe_if #(.FLAG_GRPS(2)) if2 ();
  condlogic_pipe_if #(.FLAG_GRPS(4)) if4 ();

  assign if2.StallE = stall;   assign if4.StallE = stall;
  assign if2.FlushE = flush;   assign if4.FlushE = flush;
  assign if2.ValidE = valid;   assign if4.ValidE = valid;
  assign if2.CondE = cond;     assign if4.CondE = cond;
  assign if2.FlagWE = fwe2;    assign if4.FlagWE = fwe4;
  assign if2.PCSE = pcs;       assign if4.PCSE = pcs;
  assign if2.RegWE = rw;       assign if4.RegWE = rw;
  assign if2.MemWE = mw;       assign if4.MemWE = mw;
  assign if2.BranchE = br;     assign if4.BranchE = br;
  assign if2.ALUFlags = alu;   assign if4.ALUFlags = alu;
  assign if2.FlagLd = fld;     assign if4.FlagLd = fld;
  assign if2.FlagLdVal = ldval; assign if4.FlagLdVal = ldval;

  condlogic_pipe #(.FLAG_GRPS(2), .PIPE_OUT(1'b1)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  condlogic_pipe #(.FLAG_GRPS(4), .PIPE_OUT(1'b0)) u4 (.clk(clk), .reset(reset), .bus(if4.slave));

  int total = 0;
  int bad = 0;

  logic [3:0] mf2 = '0, mf4 = '0;
  logic [2:0] mm2 = '0;

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (cc == 4'hf) return 1'b0;
    return r ^ cc[0];
  endfunction

  function automatic logic exp_cx(input logic [3:0] f);
    return valid & ~flush & cond_ok(cond, f);
  endfunction

  function automatic logic [3:0] next_flags(input logic [3:0] f, input logic [3:0] we, input int unsigned grps);
    logic [3:0] m;
    if (reset) return 4'b0000;
    if (fld) return ldval;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) m[b] = we[b / (4 / grps)];
    if (!(exp_cx(f) && !stall)) m = '0;
    return (f & ~m) | (alu & m);
  endfunction

  function automatic logic [2:0] exp_m(input logic [3:0] f);
    return {pcs, rw, mw} & {3{exp_cx(f) & ~stall}};
  endfunction

  task automatic tick();
    logic [3:0] n2, n4;
    logic [2:0] nm;
    n2 = next_flags(mf2, {2'b00, fwe2}, 2);
    n4 = next_flags(mf4, fwe4, 4);
    nm = reset ? 3'b000 : exp_m(mf2);
    @(posedge clk);
    #1;
    mf2 = n2; mf4 = n4; mm2 = nm;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; valid = 1; pcs = 0; rw = 0; mw = 0; br = 0;
    fld = 0; cond = COND_AL; alu = '0; ldval = '0; fwe2 = '0; fwe4 = '0;
  endtask

  task automatic test_reset();
    idle(); reset = 1; cond = COND_EQ; rw = 1;
    tick();
    total++; if (if2.Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags2 got=%b exp=0000", if2.Flags); end
    total++; if (if4.Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags4 got=%b exp=0000", if4.Flags); end
    total++; if (if2.RegWriteM !== 1'b0) begin bad++; $display("FAIL reset_rwm got=%b exp=0", if2.RegWriteM); end
    total++; if (if2.CondExE !== 1'b0) begin bad++; $display("FAIL reset_eq_cx got=%b exp=0", if2.CondExE); end
    reset = 0;
    tick();
    total++; if (if2.RegWriteM !== 1'b0) begin bad++; $display("FAIL eq_rwm got=%b exp=0", if2.RegWriteM); end
    cond = COND_AL; #1;
    total++; if (if4.RegWriteM !== 1'b1) begin bad++; $display("FAIL al_rwm_comb got=%b exp=1", if4.RegWriteM); end
    tick();
    total++; if (if2.RegWriteM !== 1'b1) begin bad++; $display("FAIL al_rwm_pipe got=%b exp=1", if2.RegWriteM); end
  endtask

  task automatic test_group_write();
    idle(); alu = 4'b1111; fwe2 = 2'b10; fwe4 = 4'b1100;
    tick();
    total++; if (if2.Flags !== 4'b1100) begin bad++; $display("FAIL grp_flags2 got=%b exp=1100", if2.Flags); end
    total++; if (if4.Flags !== 4'b1100) begin bad++; $display("FAIL grp_flags4 got=%b exp=1100", if4.Flags); end
    idle(); cond = COND_HI; #1;
    total++; if (if2.CondExE !== 1'b0) begin bad++; $display("FAIL hi_cx got=%b exp=0", if2.CondExE); end
    cond = COND_EQ; #1;
    total++; if (if4.CondExE !== 1'b1) begin bad++; $display("FAIL eq_cx got=%b exp=1", if4.CondExE); end
    tick();
  endtask

  task automatic test_cond_fail();
    idle(); cond = COND_NE; mw = 1; fwe2 = 2'b11; fwe4 = 4'b1111; alu = 4'b0011; #1;
    total++; if (if2.CondExE !== 1'b0) begin bad++; $display("FAIL ne_cx got=%b exp=0", if2.CondExE); end
    total++; if (if4.MemWriteM !== 1'b0) begin bad++; $display("FAIL ne_mwm_comb got=%b exp=0", if4.MemWriteM); end
    tick();
    total++; if (if2.Flags !== 4'b1100) begin bad++; $display("FAIL ne_flags got=%b exp=1100", if2.Flags); end
    total++; if (if2.MemWriteM !== 1'b0) begin bad++; $display("FAIL ne_mwm got=%b exp=0", if2.MemWriteM); end
    idle(); fld = 1; ldval = 4'b0000;
    tick();
    idle(); fwe4 = 4'b0010; alu = 4'b0010;
    tick();
    total++; if (if4.Flags !== 4'b0010) begin bad++; $display("FAIL grp4_c got=%b exp=0010", if4.Flags); end
    total++; if (if2.Flags !== 4'b0000) begin bad++; $display("FAIL grp4_other got=%b exp=0000", if2.Flags); end
  endtask

  task automatic test_stall();
    int taken = 0;
    idle(); stall = 1; br = 1; pcs = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (if2.BranchTakenE === 1'b1) taken++;
      total++; if (if4.BranchTakenE !== 1'b0) begin bad++; $display("FAIL stall_bt got=%b exp=0", if4.BranchTakenE); end
      total++; if (if4.PCSrcM !== 1'b0) begin bad++; $display("FAIL stall_pcs_comb got=%b exp=0", if4.PCSrcM); end
      tick();
      total++; if (if2.PCSrcM !== 1'b0) begin bad++; $display("FAIL stall_pcs got=%b exp=0", if2.PCSrcM); end
    end
    stall = 0; #1;
    if (if2.BranchTakenE === 1'b1) taken++;
    total++; if (if4.BranchTakenE !== 1'b1) begin bad++; $display("FAIL release_bt got=%b exp=1", if4.BranchTakenE); end
    tick();
    total++; if (if2.PCSrcM !== 1'b1) begin bad++; $display("FAIL release_pcs got=%b exp=1", if2.PCSrcM); end
    idle(); #1;
    if (if2.BranchTakenE === 1'b1) taken++;
    tick();
    total++; if (taken != 1) begin bad++; $display("FAIL bt_once got=%0d exp=1", taken); end
    total++; if (if2.PCSrcM !== 1'b0) begin bad++; $display("FAIL after_pcs got=%b exp=0", if2.PCSrcM); end
  endtask

  task automatic test_flush();
    idle(); fld = 1; ldval = 4'b0110;
    tick();
    idle(); flush = 1; rw = 1; mw = 1; fwe2 = 2'b11; fwe4 = 4'b1111; alu = 4'b1111; #1;
    total++; if (if2.CondExE !== 1'b0) begin bad++; $display("FAIL flush_cx got=%b exp=0", if2.CondExE); end
    total++; if ({if4.RegWriteM, if4.MemWriteM} !== 2'b00) begin bad++; $display("FAIL flush_m_comb got=%b exp=00", {if4.RegWriteM, if4.MemWriteM}); end
    tick();
    total++; if (if2.Flags !== 4'b0110) begin bad++; $display("FAIL flush_flags got=%b exp=0110", if2.Flags); end
    total++; if ({if2.RegWriteM, if2.MemWriteM} !== 2'b00) begin bad++; $display("FAIL flush_m got=%b exp=00", {if2.RegWriteM, if2.MemWriteM}); end
    fld = 1; ldval = 4'b1001;
    tick();
    total++; if (if4.Flags !== 4'b1001) begin bad++; $display("FAIL flush_ld got=%b exp=1001", if4.Flags); end
    idle(); cond = COND_GE; #1;
    total++; if (if2.CondExE !== 1'b1) begin bad++; $display("FAIL ge_cx got=%b exp=1", if2.CondExE); end
    cond = COND_LT; #1;
    total++; if (if4.CondExE !== 1'b0) begin bad++; $display("FAIL lt_cx got=%b exp=0", if4.CondExE); end
    tick();
  endtask

  task automatic test_ld_priority();
    idle(); fld = 1; ldval = 4'b0100; alu = 4'b1011; fwe2 = 2'b11; fwe4 = 4'b1111;
    tick();
    total++; if (if2.Flags !== 4'b0100) begin bad++; $display("FAIL ld_prio2 got=%b exp=0100", if2.Flags); end
    total++; if (if4.Flags !== 4'b0100) begin bad++; $display("FAIL ld_prio4 got=%b exp=0100", if4.Flags); end
  endtask

  task automatic test_reset_stall();
    idle(); rw = 1; mw = 1; pcs = 1;
    tick();
    total++; if (if2.MemWriteM !== 1'b1) begin bad++; $display("FAIL pre_rst_mwm got=%b exp=1", if2.MemWriteM); end
    stall = 1; reset = 1; fwe2 = 2'b11; fwe4 = 4'b1111; alu = 4'b1111;
    tick();
    total++; if ({if2.PCSrcM, if2.RegWriteM, if2.MemWriteM} !== 3'b000) begin bad++; $display("FAIL rst_stall_m got=%b exp=000", {if2.PCSrcM, if2.RegWriteM, if2.MemWriteM}); end
    total++; if (if2.Flags !== 4'b0000) begin bad++; $display("FAIL rst_stall_flags got=%b exp=0000", if2.Flags); end
    reset = 0; stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(39) == 0);
      fld   = ($urandom_range(9) == 0);
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(5) == 0);
      valid = ($urandom_range(7) != 0);
      cond  = 4'($urandom_range(15));
      alu   = 4'($urandom_range(15));
      ldval = 4'($urandom_range(15));
      fwe2  = 2'($urandom_range(3));
      fwe4  = 4'($urandom_range(15));
      {pcs, rw, mw, br} = 4'($urandom_range(15));
      #1;
      total++; if (if2.CondExE !== exp_cx(mf2)) begin bad++; $display("FAIL rnd_cx2 i=%0d got=%b exp=%b", i, if2.CondExE, exp_cx(mf2)); end
      total++; if (if4.CondExE !== exp_cx(mf4)) begin bad++; $display("FAIL rnd_cx4 i=%0d got=%b exp=%b", i, if4.CondExE, exp_cx(mf4)); end
      total++; if (if2.BranchTakenE !== (br & exp_cx(mf2) & ~stall)) begin bad++; $display("FAIL rnd_bt2 i=%0d got=%b", i, if2.BranchTakenE); end
      total++; if ({if4.PCSrcM, if4.RegWriteM, if4.MemWriteM} !== exp_m(mf4)) begin bad++; $display("FAIL rnd_m4 i=%0d got=%b exp=%b", i, {if4.PCSrcM, if4.RegWriteM, if4.MemWriteM}, exp_m(mf4)); end
      tick();
      total++; if (if2.Flags !== mf2) begin bad++; $display("FAIL rnd_flags2 i=%0d got=%b exp=%b", i, if2.Flags, mf2); end
      total++; if (if4.Flags !== mf4) begin bad++; $display("FAIL rnd_flags4 i=%0d got=%b exp=%b", i, if4.Flags, mf4); end
      total++; if ({if2.PCSrcM, if2.RegWriteM, if2.MemWriteM} !== mm2) begin bad++; $display("FAIL rnd_m2 i=%0d got=%b exp=%b", i, {if2.PCSrcM, if2.RegWriteM, if2.MemWriteM}, mm2); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_group_write();
    test_cond_fail();
    test_stall();
    test_flush();
    test_ld_priority();
    test_reset_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/condlogic_pipe.md
# condlogic_pipe

Execute-stage conditional-execution unit for the pipelined ARM core. It holds the NZCV flag register, evaluates the 4-bit condition field of the instruction in Execute, and gates register, memory, PC and branch writes. It respects pipeline stall, flush and bubble signalling, and optionally registers the gated controls into the Execute/Memory boundary. Compared with the single-cycle conditional logic, it adds configurable flag-write grouping, an explicit flag-load path, and pipeline-aware gating.

## Interface
- FLAG_GRPS, default 2: number of independently enabled flag groups; legal values are 1, 2 and 4.
  - 2 means group1 = {N,Z} and group0 = {C,V}.
  - 4 means each flag is a separate group.
- PIPE_OUT, default 1: 1 registers the gated write controls into the M stage; 0 makes them combinational from E.

Ports (name, direction, width, meaning):
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- StallE  in  1  instruction in E is held this cycle.
- FlushE  in  1  instruction in E is killed this cycle.
- ValidE  in  1  E holds a real instruction; 0 means bubble.
- CondE  in  4  ARM condition field.
- FlagWE  in  FLAG_GRPS  per-group flag-write request.
- PCSE, RegWE, MemWE, BranchE  in  1 each  ungated controls.
- ALUFlags  in  4  {N,Z,C,V} from the ALU.
- FlagLd  in  1  load flags directly (MSR / exception return).
- FlagLdVal  in  4  value for FlagLd.
- Flags  out  4  current flag register.
- CondExE  out  1  condition passed for a live instruction.
- BranchTakenE  out  1  fetch redirect, combinational.
- PCSrcM, RegWriteM, MemWriteM  out  1 each  gated controls.

## Operation
- live = ValidE & ~FlushE.
- CondExE = live & cond_eval(CondE, Flags).
- Condition codes:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 1111 (NV) 0.
- Flag update per group g (bits [4/FLAG_GRPS·(g+1)-1 : 4/FLAG_GRPS·g]): write when FlagWE[g] & CondExE & ~StallE.
- FlagLd has priority over every group write in the same cycle. The full Flags register takes FlagLdVal, regardless of StallE or FlushE.
- Gated controls (E-side): pcs = PCSE&CondExE&~StallE; rw = RegWE&CondExE&~StallE; mw = MemWE&CondExE&~StallE.
- BranchTakenE = BranchE & CondExE & ~StallE. It is always combinational and never registered, because a stalled instruction must not redirect twice.
- PIPE_OUT=1: PCSrcM/RegWriteM/MemWriteM <= pcs/rw/mw each cycle. A stall or flush therefore inserts a zero bubble into M.
- PIPE_OUT=0: PCSrcM/RegWriteM/MemWriteM = pcs/rw/mw directly.
- Condition evaluation uses the registered Flags only. No same-cycle forwarding of ALUFlags is needed, because the flag-setting predecessor commits at the end of its E cycle.

## Timing
- Reset (synchronous, on the clk edge with reset=1): Flags=4'b0000; PCSrcM/RegWriteM/MemWriteM=0. While reset=1, CondExE and BranchTakenE follow the zero-flag evaluation.
- A reset asserted mid-stall or mid-flush overrides everything. Its priority order is reset > FlagLd > group writes.
- CondExE and BranchTakenE settle in the same cycle (combinational from registered flags).
- Flag write latency is 1 cycle: an instruction in E at cycle t sees flags from writes at edges ≤ t.
- Write-control latency: 1 cycle when PIPE_OUT=1, 0 when PIPE_OUT=0.
- StallE held for N cycles: Flags unchanged by ALU writes, M receives N bubbles, and the instruction commits once on the cycle StallE drops.
- FlushE together with StallE: the flush wins; no writes occur.

## Structure
- Shared package cond_pkg holds:
  - localparams COND_EQ … COND_NV (4-bit).
  - flag indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_eval: purely combinational, Cond[3:0] + Flags[3:0] → pass.
- Top-level content:
  - live gating;
  - per-group flag registers (generate loop over FLAG_GRPS);
  - FlagLd mux;
  - PIPE_OUT generate for the M registers.
- Elaboration-time check rejects FLAG_GRPS not in {1,2,4}.

## Test plan
- Reset, then CondE=EQ(0000), RegWE=1, ValidE=1 → Flags=0000, CondExE=0, RegWriteM=0 one cycle later; CondE=AL → RegWriteM=1 next cycle.
- FLAG_GRPS=2, ALUFlags=1111, FlagWE=2'b10, CondE=AL → Flags=1100. Next instruction CondE=HI → CondExE=0 (C=0); CondE=EQ → CondExE=1.
- Flag write with CondE=NE while Z=1 → Flags unchanged, MemWriteM=0. FLAG_GRPS=4 with FlagWE=4'b0010, ALUFlags=0010 from Flags=0000 → Flags=0010.
- StallE=1 for 3 cycles with BranchE=1, CondE=AL: BranchTakenE=0 and PCSrcM=0 throughout. Cycle StallE drops → BranchTakenE=1 exactly once.
- FlushE=1 with RegWE=MemWE=1, FlagWE=all-ones, CondE=AL → no M writes, Flags unchanged. Same cycle FlagLd=1, FlagLdVal=1001 → Flags=1001, then CondE=GE → CondExE=1 (N==V).
- FlagLd=1 (FlagLdVal=0100) together with an AL group write of ALUFlags=1011 → Flags=0100. Reset asserted during StallE → all M outputs 0 and Flags=0000 after the edge.
